vga_sprite_compositor: RTL and testbench

//  N-sprite compositor between vga_counters and the VGA DAC pins. Holds per-sprite position, enable
//  and animation-frame registers written over the Avalon slave. Reads each sprite's RGB565 ROM with

---
 rtl/vga_sprite_compositor_pkg.sv | 36 +++
 rtl/vga_sprite_compositor_if.sv | 10 +
 rtl/vga_sprite_compositor_hit_unit.sv | 74 +++++++
 rtl/vga_sprite_compositor.sv | 172 +++++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_sprite_compositor_pkg.sv
// Shared types and constants for the VGA sprite compositor: register field codes,
// the background register address and the RGB565 -> RGB888 widening function.
package vga_sprite_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    F_X    = 2'd0,
    F_Y    = 2'd1,
    F_CTRL = 2'd2,
    F_RSVD = 2'd3
  } field_e;

  localparam logic [8:0] BG_ADDR = 9'h1FF;
  localparam logic [9:0] VACTIVE = 10'd480;

  // Bit replication so that full-scale 565 maps to full-scale 888.
  function automatic rgb888_t rgb565_to_888(input rgb565_t c);
    rgb888_t o;
    o.r = {c.r, c.r[4:2]};
    o.g = {c.g, c.g[5:4]};
    o.b = {c.b, c.b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/vga_sprite_compositor_if.sv
// Avalon-MM write-only slave bus carrying the sprite register writes.
interface vga_sprite_compositor_if;
  logic        chipselect;
  logic        write;
  logic [8:0]  address;
  logic [31:0] writedata;

  modport master (output chipselect, write, address, writedata);
  modport slave  (input  chipselect, write, address, writedata);
endinterface

// File: rtl/vga_sprite_compositor_hit_unit.sv
// One sprite's active (displayed) registers plus the S0 bounds test and ROM address
// calculation; hit and address are registered so the ROM sees them one clock later.
module sprite_hit_unit
  import vga_sprite_pkg::*;
#(
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32,
  parameter int NFRAMES = 4,
  parameter int AW      = 12,
  parameter int FW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_latch,
  input  logic [10:0]   i_pendX,
  input  logic [9:0]    i_pendY,
  input  logic [FW-1:0] i_pendFrame,
  input  logic          i_pendEn,
  input  logic [9:0]    i_px,
  input  logic [9:0]    i_vcount,
  output logic          o_hit,
  output logic [AW-1:0] o_romAddr
);

  logic [10:0]   r_actX;
  logic [9:0]    r_actY;
  logic [FW-1:0] r_actFrame;
  logic          r_actEn;

  logic [11:0] w_px;
  logic [11:0] w_vy;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [11:0] w_col;
  logic [11:0] w_row;
  logic        w_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_actX     <= '0;
      r_actY     <= '0;
      r_actFrame <= '0;
      r_actEn    <= 1'b0;
    end else if (i_latch) begin
      r_actX     <= i_pendX;
      r_actY     <= i_pendY;
      r_actFrame <= i_pendFrame;
      r_actEn    <= i_pendEn;
    end
  end

  // 12-bit compares so X+SPR_W never wraps: sprites past the right/bottom edge clip.
  assign w_px  = {2'b00, i_px};
  assign w_vy  = {2'b00, i_vcount};
  assign w_x   = {1'b0, r_actX};
  assign w_y   = {2'b00, r_actY};
  assign w_col = w_px - w_x;
  assign w_row = w_vy - w_y;
  assign w_hit = r_actEn
              && (w_px >= w_x) && (w_px < w_x + 12'(SPR_W))
              && (w_vy >= w_y) && (w_vy < w_y + 12'(SPR_H));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_hit     <= 1'b0;
      o_romAddr <= '0;
    end else begin
      o_hit     <= w_hit;
      o_romAddr <= AW'(32'(r_actFrame) * 32'(SPR_W * SPR_H)
                     + 32'(w_row) * 32'(SPR_W) + 32'(w_col));
    end
  end

endmodule

// File: rtl/vga_sprite_compositor.sv
// N-sprite compositor: double-buffered sprite registers, per-sprite ROM lookup, and a
// 3-clock pipeline resolving transparency/priority into RGB888 with matched syncs.
module vga_sprite_compositor
  import vga_sprite_pkg::*;
#(
  parameter int          NSPR    = 5,
  parameter int          SPR_W   = 32,
  parameter int          SPR_H   = 32,
  parameter int          NFRAMES = 4,
  parameter logic [15:0] TRANSP  = 16'hF81F,
  localparam int         AW      = $clog2(NFRAMES * SPR_W * SPR_H)
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_sprite_compositor_if.slave bus,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   blank_n_in,
  output logic [NSPR*AW-1:0]     rom_addr,
  input  logic [NSPR*16-1:0]     rom_data,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_n
);

  localparam int FW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;

  logic [10:0]   r_pendX     [NSPR];
  logic [9:0]    r_pendY     [NSPR];
  logic [FW-1:0] r_pendFrame [NSPR];
  logic          r_pendEn    [NSPR];
  logic [15:0]   r_pendBg;
  logic [15:0]   r_actBg;

  logic          w_wr;
  logic          w_latch;
  logic [6:0]    w_sprIdx;
  field_e        w_field;
  logic          w_unused;

  logic [NSPR-1:0] w_hitS0;
  logic [NSPR-1:0] r_hitS1;
  logic r_hsS0, r_vsS0, r_blankS0;
  logic r_hsS1, r_vsS1, r_blankS1;

  rgb565_t w_color;
  rgb888_t w_rgb;

  assign w_wr     = bus.chipselect && bus.write;
  assign w_sprIdx = bus.address[8:2];
  assign w_field  = field_e'(bus.address[1:0]);
  assign w_latch  = (vcount == VACTIVE) && (hcount == 11'd0);
  assign w_unused = ^bus.writedata[31:16];

  // Bus writes only ever touch the pending copy; the latch reads the pre-write value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSPR; i++) begin
        r_pendX[i]     <= '0;
        r_pendY[i]     <= '0;
        r_pendFrame[i] <= '0;
        r_pendEn[i]    <= 1'b0;
      end
      r_pendBg <= '0;
    end else if (w_wr) begin
      if (bus.address == BG_ADDR) begin
        r_pendBg <= bus.writedata[15:0];
      end else begin
        for (int i = 0; i < NSPR; i++) begin
          if (w_sprIdx == 7'(i)) begin
            case (w_field)
              F_X:     r_pendX[i] <= bus.writedata[10:0];
              F_Y:     r_pendY[i] <= bus.writedata[9:0];
              F_CTRL: begin
                r_pendFrame[i] <= bus.writedata[FW:1];
                r_pendEn[i]    <= bus.writedata[0];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_actBg <= '0;
    end else if (w_latch) begin
      r_actBg <= r_pendBg;
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_spr
    sprite_hit_unit #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .NFRAMES (NFRAMES),
      .AW      (AW),
      .FW      (FW)
    ) u_hit (
      .clk         (clk),
      .reset       (reset),
      .i_latch     (w_latch),
      .i_pendX     (r_pendX[g]),
      .i_pendY     (r_pendY[g]),
      .i_pendFrame (r_pendFrame[g]),
      .i_pendEn    (r_pendEn[g]),
      .i_px        (hcount[10:1]),
      .i_vcount    (vcount),
      .o_hit       (w_hitS0[g]),
      .o_romAddr   (rom_addr[g*AW +: AW])
    );
  end

  // Syncs and hits ride alongside the ROM access so everything lands on the same clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsS0    <= 1'b1;
      r_vsS0    <= 1'b1;
      r_blankS0 <= 1'b0;
      r_hsS1    <= 1'b1;
      r_vsS1    <= 1'b1;
      r_blankS1 <= 1'b0;
      r_hitS1   <= '0;
    end else begin
      r_hsS0    <= hs_in;
      r_vsS0    <= vs_in;
      r_blankS0 <= blank_n_in;
      r_hsS1    <= r_hsS0;
      r_vsS1    <= r_vsS0;
      r_blankS1 <= r_blankS0;
      r_hitS1   <= w_hitS0;
    end
  end

  // Scanning from the top index down lets the lowest opaque sprite overwrite the rest.
  always_comb begin
    w_color = rgb565_t'(r_actBg);
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (r_hitS1[i] && (rom_data[i*16 +: 16] != TRANSP)) begin
        w_color = rgb565_t'(rom_data[i*16 +: 16]);
      end
    end
  end

  assign w_rgb = rgb565_to_888(w_color);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
    end else begin
      VGA_R       <= r_blankS1 ? w_rgb.r : 8'd0;
      VGA_G       <= r_blankS1 ? w_rgb.g : 8'd0;
      VGA_B       <= r_blankS1 ? w_rgb.b : 8'd0;
      VGA_HS      <= r_hsS1;
      VGA_VS      <= r_vsS1;
      VGA_BLANK_n <= r_blankS1;
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Self-checking bench: a pixel-level reference model predicts every output cycle, and
// directed scenarios pin hand-computed colours, addresses and reset values.
`timescale 1ns/1ps
module tb_vga_sprite_compositor;

  localparam int          NSPR   = 5;
  localparam int          SPR_W  = 32;
  localparam int          SPR_H  = 32;
  localparam int          AW     = 12;
  localparam int          DEPTH  = 4096;
  localparam logic [15:0] TRANSP = 16'hF81F;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bn;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic hs_in = 1'b1, vs_in = 1'b1, blank_n_in = 1'b0;
  logic [NSPR*AW-1:0] rom_addr;
  logic [NSPR*16-1:0] rom_data = '0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS, VGA_VS, VGA_BLANK_n;

  vga_sprite_compositor_if bus_if ();

  vga_sprite_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .hcount      (hcount),
    .vcount      (vcount),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .blank_n_in  (blank_n_in),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_n (VGA_BLANK_n)
  );

  always #10 clk = ~clk;

  logic [15:0] mem [NSPR][DEPTH];

  // Synchronous sprite ROMs: data follows the address by one clock.
  always @(posedge clk) begin
    for (int i = 0; i < NSPR; i++)
      rom_data[i*16 +: 16] <= mem[i][rom_addr[i*AW +: AW]];
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] to888(input int c);
    int r, g, b;
    r = (c >> 11) & 31;
    g = (c >> 5) & 63;
    b = c & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // Reference model state: active (displayed) and pending register copies.
  int aX[NSPR], aY[NSPR], aF[NSPR], pX[NSPR], pY[NSPR], pF[NSPR];
  bit aEn[NSPR], pEn[NSPR];
  int aBg, pBg;
  exp_t pipe[$];
  bit prevHit[NSPR];
  int prevAddr[NSPR];
  exp_t head, nxt;
  int mPx, mVy, mColor, mAddr, mIdx;
  bit mFound, mHit;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSPR; i++) begin
        aX[i] = 0; aY[i] = 0; aF[i] = 0; aEn[i] = 0;
        pX[i] = 0; pY[i] = 0; pF[i] = 0; pEn[i] = 0;
        prevHit[i] = 0; prevAddr[i] = 0;
      end
      aBg = 0; pBg = 0;
      pipe.delete();
      repeat (3) pipe.push_back({24'd0, 3'b110});
      checkOutput("resetOutputs", 64'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}), 64'({24'd0, 3'b110}));
      checkOutput("resetRomAddr", 64'(rom_addr), 64'd0);
    end else begin
      head = pipe.pop_front();
      checkOutput("pixel", 64'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}), 64'(head));
      for (int i = 0; i < NSPR; i++)
        if (prevHit[i]) checkOutput("romAddr", 64'(rom_addr[i*AW +: AW]), 64'(prevAddr[i]));
      mPx = int'(hcount) / 2;
      mVy = int'(vcount);
      mColor = aBg;
      mFound = 0;
      for (int i = 0; i < NSPR; i++) begin
        mHit = aEn[i] && mPx >= aX[i] && mPx < aX[i] + SPR_W && mVy >= aY[i] && mVy < aY[i] + SPR_H;
        mAddr = aF[i] * SPR_W * SPR_H + (mVy - aY[i]) * SPR_W + (mPx - aX[i]);
        prevHit[i] = mHit;
        prevAddr[i] = mAddr;
        if (mHit && !mFound && mem[i][mAddr] != TRANSP) begin
          mColor = int'(mem[i][mAddr]);
          mFound = 1;
        end
      end
      nxt.rgb = blank_n_in ? to888(mColor) : 24'd0;
      nxt.hs = hs_in;
      nxt.vs = vs_in;
      nxt.bn = blank_n_in;
      pipe.push_back(nxt);
      if (vcount == 10'd480 && hcount == 11'd0) begin
        aX = pX; aY = pY; aF = pF; aEn = pEn; aBg = pBg;
      end
      if (bus_if.chipselect && bus_if.write) begin
        if (bus_if.address == 9'h1FF) begin
          pBg = int'(bus_if.writedata & 32'hFFFF);
        end else begin
          mIdx = int'(bus_if.address) / 4;
          if (mIdx < NSPR) begin
            case (bus_if.address % 4)
              0: pX[mIdx] = int'(bus_if.writedata % 2048);
              1: pY[mIdx] = int'(bus_if.writedata % 1024);
              2: begin
                pF[mIdx]  = int'((bus_if.writedata / 2) % 4);
                pEn[mIdx] = bus_if.writedata[0];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int px, input int v, input bit bn);
    hcount = 11'(px * 2);
    vcount = 10'(v);
    hs_in = 1'b1;
    vs_in = 1'b1;
    blank_n_in = bn;
  endtask

  task automatic busWrite(input logic [8:0] addr, input logic [31:0] data);
    bus_if.chipselect = 1'b1;
    bus_if.write = 1'b1;
    bus_if.address = addr;
    bus_if.writedata = data;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write = 1'b0;
  endtask

  task automatic latchFrame();
    applyStimulus(0, 479, 0);
    repeat (3) tick();
    hcount = 11'd0;
    vcount = 10'd480;
    tick();
    applyStimulus(0, 481, 0);
    repeat (3) tick();
  endtask

  task automatic holdAndCheck(input string name, input int px, input int v, input logic [23:0] exp);
    applyStimulus(px, v, 1);
    repeat (3) tick();
    checkOutput(name, 64'({VGA_R, VGA_G, VGA_B}), 64'(exp));
  endtask

  int sel, px, v, k;

  initial begin
    bus_if.chipselect = 1'b0;
    bus_if.write = 1'b0;
    bus_if.address = '0;
    bus_if.writedata = '0;
    for (int i = 0; i < NSPR; i++)
      for (int a = 0; a < DEPTH; a++)
        mem[i][a] = ($urandom_range(0, 3) == 0) ? TRANSP : 16'($urandom);
    mem[0][0]    = 16'hF800;
    mem[0][1023] = TRANSP;
    mem[1][0]    = 16'h07E0;
    mem[2][2048] = 16'h1234;
    mem[4][183]  = 16'hFFE0;

    repeat (3) tick();
    checkOutput("resetPins", 64'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}), 64'({24'd0, 3'b110}));
    reset = 1'b0;

    holdAndCheck("bgAfterReset", 50, 50, 24'h000000);
    busWrite(9'h1FF, 32'h0000FFFF);
    holdAndCheck("bgBeforeLatch", 50, 50, 24'h000000);
    latchFrame();
    holdAndCheck("bgWhite", 50, 50, 24'hFFFFFF);

    busWrite(9'd0, 32'd100);
    busWrite(9'd1, 32'd100);
    busWrite(9'd2, 32'd1);
    latchFrame();
    holdAndCheck("spr0Red", 100, 100, 24'hFF0000);
    holdAndCheck("spr0RightEdge", 132, 100, 24'hFFFFFF);

    busWrite(9'd4, 32'd131);
    busWrite(9'd5, 32'd131);
    busWrite(9'd6, 32'd1);
    latchFrame();
    holdAndCheck("overlapTransp", 131, 131, 24'h00FF00);
    applyStimulus(0, 0, 1);
    repeat (4) tick();
    mem[0][1023] = 16'h001F;
    holdAndCheck("overlapOpaque", 131, 131, 24'h0000FF);

    applyStimulus(0, 50, 1);
    busWrite(9'd0, 32'd200);
    holdAndCheck("midFrameOldX", 100, 100, 24'hFF0000);
    holdAndCheck("midFrameNewXNotYet", 200, 100, 24'hFFFFFF);
    latchFrame();
    holdAndCheck("movedNewX", 200, 100, 24'hFF0000);
    holdAndCheck("movedOldXGone", 100, 100, 24'hFFFFFF);

    applyStimulus(0, 479, 0);
    repeat (3) tick();
    hcount = 11'd0;
    vcount = 10'd480;
    busWrite(9'd0, 32'd300);
    applyStimulus(0, 481, 0);
    repeat (3) tick();
    holdAndCheck("latchClkWriteDeferred", 200, 100, 24'hFF0000);
    latchFrame();
    holdAndCheck("latchClkWriteApplied", 300, 100, 24'hFF0000);

    busWrite(9'd8, 32'd400);
    busWrite(9'd9, 32'd200);
    busWrite(9'd10, 32'd5);
    latchFrame();
    applyStimulus(400, 200, 1);
    tick();
    checkOutput("frame2RomAddr", 64'(rom_addr[2*AW +: AW]), 64'd2048);
    repeat (2) tick();
    checkOutput("frame2Colour", 64'({VGA_R, VGA_G, VGA_B}), 64'h1045A5);

    busWrite(9'd12, 32'd2030);
    busWrite(9'd13, 32'd0);
    busWrite(9'd14, 32'd1);
    busWrite(9'd16, 32'd1000);
    busWrite(9'd17, 32'd0);
    busWrite(9'd18, 32'd1);
    busWrite(9'd20, 32'd555);
    busWrite(9'd3, 32'd777);
    latchFrame();
    holdAndCheck("clipNoWrap", 5, 5, 24'hFFFFFF);
    holdAndCheck("clipRightEdge", 1023, 5, 24'hFFFF00);
    holdAndCheck("ignoredWrites", 300, 100, 24'hFF0000);

    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 10) begin
        k = $urandom_range(0, 9);
        if (k == 9) begin
          busWrite(9'h1FF, $urandom);
        end else begin
          sel = $urandom_range(0, 3);
          case (sel)
            0: busWrite(9'(k * 4),     ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 1100)));
            1: busWrite(9'(k * 4 + 1), ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 520)));
            default: busWrite(9'(k * 4 + sel), $urandom);
          endcase
        end
      end else if (sel < 13) begin
        latchFrame();
      end else begin
        k = $urandom_range(0, NSPR - 1);
        if ($urandom_range(0, 3) != 0) begin
          px = aX[k] + $urandom_range(0, 40) - 4;
          v  = aY[k] + $urandom_range(0, 40) - 4;
        end else begin
          px = $urandom_range(0, 1023);
          v  = $urandom_range(0, 600);
        end
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        if (v == 480) v = 481;
        hcount = 11'(px * 2 + $urandom_range(0, 1));
        vcount = 10'(v);
        hs_in = 1'($urandom);
        vs_in = 1'($urandom);
        blank_n_in = ($urandom_range(0, 7) != 0);
        tick();
      end
    end

    busWrite(9'd0, 32'd100);
    busWrite(9'd1, 32'd100);
    busWrite(9'd2, 32'd1);
    latchFrame();
    holdAndCheck("preResetRed", 100, 100, 24'hFF0000);
    #3 reset = 1'b1;
    #1;
    checkOutput("midLineResetPins", 64'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_n}), 64'({24'd0, 3'b110}));
    checkOutput("midLineResetRomAddr", 64'(rom_addr), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    holdAndCheck("postResetBlack", 100, 100, 24'h000000);
    latchFrame();
    holdAndCheck("postResetDisabled", 100, 100, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
